am_argmax_ctrl: RTL and testbench
=================================

AM_ARGMAX_CTRL -- requirements
Module: am_argmax_ctrl

Interface
REQ-001 Param NUM_CLASSES, default 26, number of class HVs compared per inference.
REQ-002 Param CHUNKS_PER_HV, default 4, 1024-dim chunks per 4096-dim HV.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one inference of the current query HV; sampled in IDLE only.
REQ-006 comparing_query_hv_with_class_hv  out  1  accumulator add-enable to tree adder.
REQ-007 inferring_class  out  1  accumulator hold-enable to tree adder.
REQ-008 class_idx  out  5  class HV currently addressed in the AM.
REQ-009 chunk_idx  out  2  1024-dim chunk currently presented.
REQ-010 similarity_value  in  13  accumulated similarity from tree adder.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 pred_valid / pred_ready  out / in  1 / 1  result handshake.
REQ-013 pred_class  out  5 and pred_score  out  13  winning class and its similarity.

Function
REQ-014 Moore FSM, states IDLE, COMPARE, EVAL, CLEAR, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> COMPARE, class_idx=0, chunk_idx=0; start ignored in all other states.
REQ-016 COMPARE: comparing=1, inferring=0; chunk_idx increments each cycle; after CHUNKS_PER_HV cycles -> EVAL.
REQ-017 EVAL (1 cycle): comparing=0, inferring=1; sample similarity_value as final score of class_idx.
REQ-018 Class 0 loads best unconditionally; later classes replace best only if score > best (strict), so ties keep the lowest index.
REQ-019 After EVAL: class_idx < NUM_CLASSES-1 -> CLEAR; else -> DONE.
REQ-020 CLEAR (1 cycle): both enables 0 (adder clears); class_idx increments, chunk_idx=0 -> COMPARE.
REQ-021 DONE: both enables 0; pred_valid=1; pred_class/pred_score stable until transfer.
REQ-022 Transfer when pred_valid & pred_ready -> IDLE next cycle, pred_valid=0; start in the same cycle is ignored.
REQ-023 Latency: pred_valid rises 155 cycles after the edge sampling start (defaults: 25x6 + 5).
REQ-024 Comparing and inferring are never high together; both low in IDLE and DONE.

Reset
REQ-025 nrst low: state=IDLE, all outputs 0, best register 0, regardless of in-progress inference.
REQ-026 After reset release, no action until a fresh start in IDLE.

Configuration
REQ-027 Macro AM_ARGMAX_MARGIN_EN defined: adds output pred_margin (13 bits) = best - second-best score, tracked with the same strict-greater rule; valid with pred_valid.
REQ-028 AM_ARGMAX_MARGIN_EN undefined: no pred_margin port or second-best register; all other behaviour identical.

Structure
REQ-029 Package hdc_am_pkg holds DIMS_PER_CC, NUM_CLASSES, CHUNKS_PER_HV, SIM_W=13, CLASS_W=5 and the FSM state enum typedef.
REQ-030 Sub-module am_max_tracker: clear/load/compare-update of best (and second-best when enabled) score and index.

Verification
REQ-031 Scores 10,20,..,260 for classes 0..25 -> pred_class=25, pred_score=260, pred_valid 155 cycles after start.
REQ-032 Class 7 = 4000, all others 100 -> pred_class=7, pred_score=4000; margin=3900 when enabled.
REQ-033 Classes 3 and 9 both 500, rest 0 -> pred_class=3 (tie keeps lower index); margin=0 when enabled.
REQ-034 pred_ready held 0 for 20 cycles in DONE -> outputs stable, start pulses ignored; ready=1 -> IDLE next cycle.
REQ-035 nrst asserted during class 12 COMPARE -> all outputs 0 immediately; a new start yields a correct full result.
REQ-036 Each class -> exactly 4 comparing cycles, 1 inferring cycle, 1 cycle with both enables low; enables never high together.

Source files
------------

// File: rtl/hdc_am_pkg.sv
// Shared constants and FSM state type for the associative-memory argmax controller.
// The optional margin output is enabled with the AM_ARGMAX_MARGIN_EN macro.
package hdc_am_pkg;

  localparam int DIMS_PER_CC   = 1024;
  localparam int NUM_CLASSES   = 26;
  localparam int CHUNKS_PER_HV = 4;
  localparam int SIM_W         = 13;
  localparam int CLASS_W       = 5;
  localparam int CHUNK_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_EVAL    = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_DONE    = 3'd4
  } am_state_e;

endpackage

// File: rtl/am_max_tracker.sv
// Best (and, with AM_ARGMAX_MARGIN_EN, second-best) score tracker.
// Strict-greater replacement keeps the lowest index on ties.
module am_max_tracker
  import hdc_am_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               first_i,
  input  logic [SIM_W-1:0]   score_i,
  input  logic [CLASS_W-1:0] idx_i,
`ifdef AM_ARGMAX_MARGIN_EN
  output logic [SIM_W-1:0]   margin_o,
`endif
  output logic [SIM_W-1:0]   best_score_o,
  output logic [CLASS_W-1:0] best_idx_o
);

  logic [SIM_W-1:0]   best_q, best_d;
  logic [CLASS_W-1:0] idx_q, idx_d;

`ifdef AM_ARGMAX_MARGIN_EN
  logic [SIM_W-1:0] second_q, second_d;
  logic [SIM_W-1:0] margin_q;

  always_comb begin
    best_d   = best_q;
    idx_d    = idx_q;
    second_d = second_q;
    if (clear_i) begin
      best_d   = '0;
      idx_d    = '0;
      second_d = '0;
    end else if (load_i) begin
      if (first_i || (score_i > best_q)) begin
        best_d   = score_i;
        idx_d    = idx_i;
        second_d = first_i ? '0 : best_q;
      end else if (score_i > second_q) begin
        second_d = score_i;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      best_q   <= '0;
      idx_q    <= '0;
      second_q <= '0;
      margin_q <= '0;
    end else begin
      best_q   <= best_d;
      idx_q    <= idx_d;
      second_q <= second_d;
      margin_q <= best_d - second_d;
    end
  end

  assign margin_o = margin_q;
`else
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (clear_i) begin
      best_d = '0;
      idx_d  = '0;
    end else if (load_i) begin
      if (first_i || (score_i > best_q)) begin
        best_d = score_i;
        idx_d  = idx_i;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end
`endif

  assign best_score_o = best_q;
  assign best_idx_o   = idx_q;

endmodule

// File: rtl/am_argmax_ctrl.sv
// Argmax sequencer over class HVs: walks chunks/classes, tracks the best score.
// Optional pred_margin output with AM_ARGMAX_MARGIN_EN.
module am_argmax_ctrl
  import hdc_am_pkg::*;
#(
  parameter int NUM_CLASSES   = hdc_am_pkg::NUM_CLASSES,
  parameter int CHUNKS_PER_HV = hdc_am_pkg::CHUNKS_PER_HV
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  output logic               comparing_query_hv_with_class_hv,
  output logic               inferring_class,
  output logic [CLASS_W-1:0] class_idx,
  output logic [CHUNK_W-1:0] chunk_idx,
  input  logic [SIM_W-1:0]   similarity_value,
  output logic               busy,
  output logic               pred_valid,
  input  logic               pred_ready,
  output logic [CLASS_W-1:0] pred_class,
  output logic [SIM_W-1:0]   pred_score,
`ifdef AM_ARGMAX_MARGIN_EN
  output logic [SIM_W-1:0]   pred_margin,
`endif
  output am_state_e          state_dbg
);

  // Result handshake: pred_valid holds with pred_class/pred_score stable until a
  // cycle where pred_valid && pred_ready; the FSM returns to IDLE on the next edge.

  am_state_e          state_q;
  logic               cmp_q, inf_q, busy_q, valid_q;
  logic [CLASS_W-1:0] class_q;
  logic [CHUNK_W-1:0] chunk_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cmp_q   <= 1'b0;
      inf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= '0;
      chunk_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_COMPARE;
            cmp_q   <= 1'b1;
            inf_q   <= 1'b0;
            busy_q  <= 1'b1;
            class_q <= '0;
            chunk_q <= '0;
          end
        end
        ST_COMPARE: begin
          if (chunk_q == CHUNK_W'(CHUNKS_PER_HV - 1)) begin
            state_q <= ST_EVAL;
            cmp_q   <= 1'b0;
            inf_q   <= 1'b1;
          end else begin
            chunk_q <= chunk_q + 1'b1;
          end
        end
        ST_EVAL: begin
          inf_q <= 1'b0;
          if (class_q < CLASS_W'(NUM_CLASSES - 1)) begin
            state_q <= ST_CLEAR;
          end else begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Adder clears this cycle; next class starts from chunk 0.
          state_q <= ST_COMPARE;
          cmp_q   <= 1'b1;
          class_q <= class_q + 1'b1;
          chunk_q <= '0;
        end
        ST_DONE: begin
          if (pred_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cmp_q   <= 1'b0;
          inf_q   <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  am_max_tracker u_tracker (
    .clk          (clk),
    .nrst         (nrst),
    .clear_i      ((state_q == ST_IDLE) && start),
    .load_i       (state_q == ST_EVAL),
    .first_i      (class_q == '0),
    .score_i      (similarity_value),
    .idx_i        (class_q),
`ifdef AM_ARGMAX_MARGIN_EN
    .margin_o     (pred_margin),
`endif
    .best_score_o (pred_score),
    .best_idx_o   (pred_class)
  );

  assign comparing_query_hv_with_class_hv = cmp_q;
  assign inferring_class                  = inf_q;
  assign class_idx                        = class_q;
  assign chunk_idx                        = chunk_q;
  assign busy                             = busy_q;
  assign pred_valid                       = valid_q;
  assign state_dbg                        = state_q;

endmodule

// File: tb/tb_am_argmax_ctrl.sv
// Self-checking bench for am_argmax_ctrl: directed and random score sets against an argmax model.
// Margin checks are compiled in with AM_ARGMAX_MARGIN_EN.
module tb_am_argmax_ctrl;
  import hdc_am_pkg::*;

  localparam int NC = 26;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               start = 1'b0;
  logic               cmp, inf;
  logic [CLASS_W-1:0] class_idx;
  logic [CHUNK_W-1:0] chunk_idx;
  logic [SIM_W-1:0]   similarity_value = '0;
  logic               busy, pred_valid;
  logic               pred_ready = 1'b0;
  logic [CLASS_W-1:0] pred_class;
  logic [SIM_W-1:0]   pred_score;
`ifdef AM_ARGMAX_MARGIN_EN
  logic [SIM_W-1:0]   pred_margin;
`endif
  am_state_e          state_dbg;

  int unsigned scores [32];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cmp_cnt, inf_cnt, low_cnt, both_hi;
  logic [31:0] exp_q[$];

  am_argmax_ctrl dut (
    .clk                              (clk),
    .nrst                             (nrst),
    .start                            (start),
    .comparing_query_hv_with_class_hv (cmp),
    .inferring_class                  (inf),
    .class_idx                        (class_idx),
    .chunk_idx                        (chunk_idx),
    .similarity_value                 (similarity_value),
    .busy                             (busy),
    .pred_valid                       (pred_valid),
    .pred_ready                       (pred_ready),
    .pred_class                       (pred_class),
    .pred_score                       (pred_score),
`ifdef AM_ARGMAX_MARGIN_EN
    .pred_margin                      (pred_margin),
`endif
    .state_dbg                        (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Adder model and enable monitor: score of the addressed class, sampled mid-cycle.
  initial begin
    cmp_cnt = 0; inf_cnt = 0; low_cnt = 0; both_hi = 0;
    forever begin
      @(negedge clk);
      similarity_value = SIM_W'(scores[class_idx]);
      if (cmp && inf) both_hi++;
      if (cmp) cmp_cnt++;
      if (inf) inf_cnt++;
      if (busy && !cmp && !inf && !pred_valid) low_cnt++;
    end
  end

  // Reference: first index holding the maximum score; margin = max - max of the others.
  function automatic logic [31:0] model_best();
    int bi = 0;
    for (int i = 1; i < NC; i++) if (scores[i] > scores[bi]) bi = i;
    return {bi[15:0], 16'(scores[bi])};
  endfunction

  function automatic int unsigned model_margin();
    int bi = 0;
    int unsigned sec = 0;
    for (int i = 1; i < NC; i++) if (scores[i] > scores[bi]) bi = i;
    for (int i = 0; i < NC; i++) if (i != bi && scores[i] > sec) sec = scores[i];
    return scores[bi] - sec;
  endfunction

  // Runs one inference; holds pred_ready low for hold cycles in DONE with start pulses.
  task automatic run_inf(input string name, input int hold);
    int cyc;
    logic [31:0] exp;
    logic [CLASS_W-1:0] c0;
    logic [SIM_W-1:0] s0;
    logic stable;
    exp_q.push_back(model_best());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cmp_cnt = 0; inf_cnt = 0; low_cnt = 0; both_hi = 0;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      cyc++;
      #1;
      if (pred_valid) break;
    end
    exp = exp_q.pop_front();
    check({name, " latency"}, cyc, 155);
    check({name, " pred_class"}, 32'(pred_class), 32'(exp[31:16]));
    check({name, " pred_score"}, 32'(pred_score), 32'(exp[15:0]));
`ifdef AM_ARGMAX_MARGIN_EN
    check({name, " pred_margin"}, 32'(pred_margin), model_margin());
`endif
    check({name, " cmp_cycles"}, cmp_cnt, NC * 4);
    check({name, " inf_cycles"}, inf_cnt, NC);
    check({name, " low_cycles"}, low_cnt, NC - 1);
    check({name, " both_high"}, both_hi, 0);
    check({name, " done_enables"}, {cmp, inf, busy}, 3'b001);
    c0 = pred_class; s0 = pred_score; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
      @(posedge clk);
      #1;
      if (!pred_valid || pred_class != c0 || pred_score != s0 || state_dbg != ST_DONE) stable = 1'b0;
    end
    if (hold > 0) check({name, " hold_stable"}, stable, 1'b1);
    @(negedge clk);
    start = 1'b1;
    pred_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pred_ready = 1'b0;
    check({name, " after_xfer"}, {pred_valid, busy, 3'(state_dbg)}, {2'b00, 3'(ST_IDLE)});
    repeat (3) @(posedge clk);
    #1 check({name, " idle_stays"}, {busy, cmp, inf}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) scores[i] = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {cmp, inf, busy, pred_valid, class_idx, chunk_idx, pred_class, pred_score},
             '0);
    @(negedge clk) nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("no_action_after_reset", {busy, 3'(state_dbg)}, {1'b0, 3'(ST_IDLE)});

    for (int i = 0; i < NC; i++) scores[i] = 10 * (i + 1);
    run_inf("ascending", 0);

    for (int i = 0; i < NC; i++) scores[i] = 100;
    scores[7] = 4000;
    run_inf("peak7", 20);

    for (int i = 0; i < NC; i++) scores[i] = 0;
    scores[3] = 500; scores[9] = 500;
    run_inf("tie3_9", 2);

    // Reset in the middle of class 12's compare phase.
    for (int i = 0; i < NC; i++) scores[i] = $urandom_range(0, 8191);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (class_idx == 12 && cmp) break;
    end
    check("reached_class12", {28'(class_idx), 3'b0, cmp}, {28'd12, 3'b0, 1'b1});
    #2 nrst = 1'b0;
    #1 check("async_reset_outputs",
             {cmp, inf, busy, pred_valid, class_idx, chunk_idx, pred_class, pred_score}, '0);
    @(negedge clk) nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_after_midreset", {busy, 3'(state_dbg)}, {1'b0, 3'(ST_IDLE)});
    run_inf("post_reset", 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++)
        scores[i] = (r % 2 == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 7);
      run_inf($sformatf("rand%0d", r), $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
